tf_addr_seq: RTL and testbench



---
 rtl/tf_addr_seq.sv | 139 +++++++++++++
 tb/tb_tf_addr_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tf_addr_seq.sv
// Twiddle ROM address sequencer: walks stages/groups from one start pulse; registered outputs, first beat one cycle after start.
// Beats stall in place while tf_valid && !tf_ready; counters advance only on acceptance.
module tf_addr_seq #(
    parameter int NUM_STAGES      = 5,
    parameter int BEATS_PER_STAGE = 256
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              mode,
    output logic                                              busy,
    output logic                                              tf_valid,
    input  logic                                              tf_ready,
    output logic [2*NUM_STAGES-2:0]                           tf_address,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] tf_stage,
    output logic                                              tf_last,
    output logic                                              done
);

    localparam int AW = 2*NUM_STAGES - 1;
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int BW = $clog2(BEATS_PER_STAGE) + 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [AW-1:0]   k_q, k_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            accept;
    logic            finish;

    // B(s) = 1 + 4 + ... + 4^(s-1); s may equal NUM_STAGES for the INTT upper bound.
    function automatic logic [AW-1:0] stage_base(input int s);
        logic [AW-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i < s) b = b + (AW'(1) << (2*i));
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] hold_max(input logic [SW-1:0] s);
        return BW'(BEATS_PER_STAGE >> (2*int'(s))) - BW'(1);
    endfunction

    function automatic logic [AW-1:0] group_max(input logic [SW-1:0] s);
        return (AW'(1) << (2*int'(s))) - AW'(1);
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic m, input logic [SW-1:0] s,
                                              input logic [AW-1:0] k);
        if (m) return stage_base(int'(s) + 1) - AW'(1) - k;
        else   return stage_base(int'(s)) + k;
    endfunction

    function automatic logic last_of(input logic m, input logic [SW-1:0] s,
                                     input logic [AW-1:0] k, input logic [BW-1:0] b);
        return (s == (m ? '0 : LAST_STAGE)) && (k == group_max(s)) && (b == hold_max(s));
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        k_d     = k_q;
        beat_d  = beat_q;
        finish  = 1'b0;
        accept  = tf_valid && tf_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    stage_d = mode ? LAST_STAGE : '0;
                    k_d     = '0;
                    beat_d  = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (tf_last) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else if (beat_q == hold_max(stage_q)) begin
                        beat_d = '0;
                        if (k_q == group_max(stage_q)) begin
                            k_d     = '0;
                            stage_d = mode_q ? stage_q - SW'(1) : stage_q + SW'(1);
                        end else begin
                            k_d = k_q + AW'(1);
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next-state counters so every port is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            stage_q    <= '0;
            k_q        <= '0;
            beat_q     <= '0;
            busy       <= 1'b0;
            tf_valid   <= 1'b0;
            tf_address <= '0;
            tf_stage   <= '0;
            tf_last    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            stage_q  <= stage_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            done     <= finish;
            busy     <= (state_d == RUN);
            tf_valid <= (state_d == RUN);
            if (state_d == RUN) begin
                tf_address <= addr_of(mode_d, stage_d, k_d);
                tf_stage   <= stage_d;
                tf_last    <= last_of(mode_d, stage_d, k_d, beat_d);
            end else begin
                tf_address <= '0;
                tf_stage   <= '0;
                tf_last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tf_addr_seq.sv
// Directed bench for tf_addr_seq: default (5 stages, 256 beats) and small (3 stages, 16 beats) instances.
module tb_tf_addr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, mode, ready, sel;

    logic       d_busy, d_valid, d_last, d_done;
    logic [8:0] d_addr;
    logic [2:0] d_stage;
    logic       s_busy, s_valid, s_last, s_done;
    logic [4:0] s_addr;
    logic [1:0] s_stage;

    tf_addr_seq dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode),
        .busy(d_busy), .tf_valid(d_valid), .tf_ready(ready),
        .tf_address(d_addr), .tf_stage(d_stage), .tf_last(d_last), .done(d_done)
    );

    tf_addr_seq #(.NUM_STAGES(3), .BEATS_PER_STAGE(16)) dut_s (
        .clk(clk), .rst(rst), .start(start & sel), .mode(mode),
        .busy(s_busy), .tf_valid(s_valid), .tf_ready(ready),
        .tf_address(s_addr), .tf_stage(s_stage), .tf_last(s_last), .done(s_done)
    );

    int o_addr, o_stage;
    logic o_busy, o_valid, o_last, o_done;
    assign o_addr  = sel ? int'(s_addr)  : int'(d_addr);
    assign o_stage = sel ? int'(s_stage) : int'(d_stage);
    assign o_busy  = sel ? s_busy  : d_busy;
    assign o_valid = sel ? s_valid : d_valid;
    assign o_last  = sel ? s_last  : d_last;
    assign o_done  = sel ? s_done  : d_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_of(input int s);
        return ((1 << (2*s)) - 1) / 3;
    endfunction

    function automatic int exp_stage(input int n, input bit m, input int ns, input int bps);
        int pos;
        pos = n / bps;
        return m ? (ns - 1 - pos) : pos;
    endfunction

    function automatic int exp_addr(input int n, input bit m, input int ns, input int bps);
        int s, h, k;
        s = exp_stage(n, m, ns, bps);
        h = bps >> (2*s);
        k = (n % bps) / h;
        return m ? (base_of(s + 1) - 1 - k) : (base_of(s) + k);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  int'(o_busy),  0);
        check({tag, "_valid"}, int'(o_valid), 0);
        check({tag, "_addr"},  o_addr,        0);
        check({tag, "_stage"}, o_stage,       0);
        check({tag, "_last"},  int'(o_last),  0);
        check({tag, "_done"},  int'(o_done),  0);
    endtask

    // One transform; ends on the negedge where done is high (unless aborted by reset).
    task automatic run(input bit m, input int duty, input int glitch_at, input int abort_at,
                       input bit immediate);
        int ns, bps, total, n, cyc, dc0, paddr, pstage, plast;
        bit stalled;
        ns    = sel ? 3 : 5;
        bps   = sel ? 16 : 256;
        total = ns * bps;
        n = 0; cyc = 0; stalled = 1'b0; paddr = 0; pstage = 0; plast = 0;
        dc0 = done_cnt;
        if (!immediate) @(negedge clk);
        start = 1'b1;
        mode  = m;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",  int'(o_busy),  1);
        check("start_valid", int'(o_valid), 1);
        check("start_done",  int'(o_done),  0);
        while (n < total && cyc < total*20 + 50) begin
            check("run_valid", int'(o_valid), 1);
            if (stalled) begin
                check("stall_addr",  o_addr,       paddr);
                check("stall_stage", o_stage,      pstage);
                check("stall_last",  int'(o_last), plast);
            end
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("abort");
                @(negedge clk);
                rst   = 1'b0;
                ready = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_no_done", done_cnt - dc0, 0);
                check("abort_idle_busy", int'(o_busy), 0);
                return;
            end
            start = (n == glitch_at);
            mode  = (glitch_at >= 0 && n >= glitch_at) ? ~m : m;
            ready = ($urandom_range(99) < duty);
            if (ready) begin
                check("addr",  o_addr,       exp_addr(n, m, ns, bps));
                check("stage", o_stage,      exp_stage(n, m, ns, bps));
                check("last",  int'(o_last), (n == total - 1) ? 1 : 0);
                n++;
            end
            paddr   = o_addr;
            pstage  = o_stage;
            plast   = int'(o_last);
            stalled = !ready;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        mode  = m;
        ready = 1'b0;
        check("beats_accepted", n, total);
        check("end_done",  int'(o_done),  1);
        check("end_valid", int'(o_valid), 0);
        check("end_busy",  int'(o_busy),  0);
        check("end_last",  int'(o_last),  0);
        check("done_count", done_cnt - dc0, 1);
    endtask

    initial begin
        sel = 1'b0; rst = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        check("reset_small_valid", int'(s_valid), 0);
        check("reset_small_addr",  int'(s_addr),  0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 100, -1, -1, 1'b0);   // NTT full throughput
        run(1'b1, 100, -1, -1, 1'b1);   // INTT started on the done cycle
        @(negedge clk);
        check("post_done_low", int'(o_done), 0);
        run(1'b0, 30, -1, -1, 1'b0);    // NTT with backpressure
        run(1'b1, 30, -1, -1, 1'b0);    // INTT with backpressure
        run(1'b0, 100, 300, -1, 1'b0);  // start pulse + mode flip mid-run
        run(1'b1, 60, 100, -1, 1'b0);
        run(1'b0, 100, -1, 700, 1'b0);  // reset at beat 700
        run(1'b0, 100, -1, -1, 1'b0);   // restart after abort

        @(negedge clk);
        sel = 1'b1;
        run(1'b0, 100, -1, -1, 1'b0);   // small NTT
        run(1'b1, 50, -1, -1, 1'b0);    // small INTT with backpressure
        @(negedge clk);
        check("final_done_low", int'(o_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
